// File: rtl/ram_dist_sp.sv
// Single-port distributed RAM with a self-sequencing clear engine.
// Selectable active clock edge, optional registered read port with READ_FIRST/WRITE_FIRST.
module ram_dist_sp #(
    parameter int               WIDTH     = 1,
    parameter int               ADDR_W    = 6,
    parameter logic [WIDTH-1:0] INIT_WORD = '0,
    parameter int               CLK_INV   = 1,
    parameter int               OUT_REG   = 0,
    parameter int               WR_MODE   = 0
) (
    input  logic              WCLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] A,
    input  logic [WIDTH-1:0]  D,
    input  logic              WE,
    input  logic              CLR,
    output logic [WIDTH-1:0]  O,
    output logic              BUSY
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    logic              clk_act;
    state_t            state_reg;
    state_t            state_next;
    logic [ADDR_W-1:0] cnt_reg;
    logic [ADDR_W-1:0] cnt_next;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic [WIDTH-1:0]  mem [DEPTH];

    // Every sequential element runs on this one net, so the edge choice lives in one place.
    generate
        if (CLK_INV != 0) begin : g_clk_fall
            assign clk_act = ~WCLK;
        end else begin : g_clk_rise
            assign clk_act = WCLK;
        end
    endgenerate

    always_ff @(posedge clk_act or posedge RST) begin
        if (RST) begin
            state_reg <= CLEAR;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        wr_en      = 1'b0;
        wr_addr    = A;
        wr_data    = D;
        case (state_reg)
            CLEAR: begin
                wr_en    = 1'b1;
                wr_addr  = cnt_reg;
                wr_data  = INIT_WORD;
                cnt_next = cnt_reg + ADDR_W'(1);
                if (&cnt_reg) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                // A clear request wins over a coincident user write.
                if (CLR) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end else if (WE) begin
                    wr_en = 1'b1;
                end
            end
            default: begin
                state_next = CLEAR;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_act) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign BUSY = (state_reg == CLEAR);

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [WIDTH-1:0] o_reg;

            // Read port freezes while the clear engine owns the array.
            always_ff @(posedge clk_act or posedge RST) begin
                if (RST) begin
                    o_reg <= '0;
                end else if (state_reg == IDLE) begin
                    if (WE && (WR_MODE != 0)) begin
                        o_reg <= D;
                    end else begin
                        o_reg <= mem[A];
                    end
                end
            end

            assign O = o_reg;
        end else begin : g_oasync
            assign O = mem[A];
        end
    endgenerate

endmodule

// File: tb/tb_ram_dist_sp.sv
// Directed self-checking bench for ram_dist_sp across five parameterisations
// sharing one clock and reset.
module tb_ram_dist_sp;

    logic       WCLK = 1'b0;
    logic       RST;
    logic [5:0] A;
    logic [7:0] D;
    logic       WE;
    logic       CLR;
    logic [5:0] A4;
    logic [7:0] D4;
    logic       WE4;
    logic       CLR4;

    logic       o0;
    logic [7:0] o1, o2, o3, o4;
    logic       busy0, busy1, busy2, busy3, busy4;

    int checks   = 0;
    int failures = 0;

    always #5 WCLK = ~WCLK;

    // u0: defaults (1 bit, 64 words, falling edge, async read)
    ram_dist_sp u0 (
        .WCLK(WCLK), .RST(RST), .A(A), .D(D[0]), .WE(WE), .CLR(CLR), .O(o0), .BUSY(busy0)
    );
    // u1: 8 bit, INIT_WORD A5, async read
    ram_dist_sp #(.WIDTH(8), .ADDR_W(6), .INIT_WORD(8'hA5), .CLK_INV(1), .OUT_REG(0), .WR_MODE(0)) u1 (
        .WCLK(WCLK), .RST(RST), .A(A), .D(D), .WE(WE), .CLR(CLR), .O(o1), .BUSY(busy1)
    );
    // u2: registered read, READ_FIRST
    ram_dist_sp #(.WIDTH(8), .ADDR_W(6), .INIT_WORD(8'h00), .CLK_INV(1), .OUT_REG(1), .WR_MODE(0)) u2 (
        .WCLK(WCLK), .RST(RST), .A(A), .D(D), .WE(WE), .CLR(CLR), .O(o2), .BUSY(busy2)
    );
    // u3: registered read, WRITE_FIRST
    ram_dist_sp #(.WIDTH(8), .ADDR_W(6), .INIT_WORD(8'h00), .CLK_INV(1), .OUT_REG(1), .WR_MODE(1)) u3 (
        .WCLK(WCLK), .RST(RST), .A(A), .D(D), .WE(WE), .CLR(CLR), .O(o3), .BUSY(busy3)
    );
    // u4: rising-edge variant with its own stimulus
    ram_dist_sp #(.WIDTH(8), .ADDR_W(6), .INIT_WORD(8'h00), .CLK_INV(0), .OUT_REG(0), .WR_MODE(0)) u4 (
        .WCLK(WCLK), .RST(RST), .A(A4), .D(D4), .WE(WE4), .CLR(CLR4), .O(o4), .BUSY(busy4)
    );

    task automatic step();
        @(negedge WCLK);
        #1;
    endtask

    task automatic step_rise();
        @(posedge WCLK);
        #1;
    endtask

    task automatic test_reset();
        int n0;
        int n4;
        RST = 1'b1; A = '0; D = '0; WE = 1'b0; CLR = 1'b0;
        A4 = '0; D4 = '0; WE4 = 1'b0; CLR4 = 1'b0;
        #2;
        checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL rst_busy0 got=%b exp=1", busy0); end
        checks++; if (busy4 !== 1'b1) begin failures++; $display("FAIL rst_busy4 got=%b exp=1", busy4); end
        checks++; if (o2 !== 8'h00) begin failures++; $display("FAIL rst_o2 got=%h exp=00", o2); end
        checks++; if (o3 !== 8'h00) begin failures++; $display("FAIL rst_o3 got=%h exp=00", o3); end
        step(); step();
        checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL rst_hold_busy got=%b exp=1", busy0); end
        RST = 1'b0;
        n0 = 0; n4 = 0;
        for (int i = 1; i <= 200; i++) begin
            step();
            if (n0 == 0 && busy0 !== 1'b1) n0 = i;
            if (n4 == 0 && busy4 !== 1'b1) n4 = i;
            if (n0 != 0 && n4 != 0) break;
        end
        checks++; if (n0 != 64) begin failures++; $display("FAIL rst_clear_len_fall got=%0d exp=64", n0); end
        checks++; if (n4 != 64) begin failures++; $display("FAIL rst_clear_len_rise got=%0d exp=64", n4); end
        $display("reset: clear lengths fall=%0d rise=%0d", n0, n4);
    endtask

    task automatic test_read_zero();
        for (int a = 0; a < 64; a++) begin
            A = 6'(a);
            #1;
            checks++; if (o0 !== 1'b0) begin failures++; $display("FAIL init_o0 a=%0d got=%b exp=0", a, o0); end
            checks++; if (o1 !== 8'hA5) begin failures++; $display("FAIL init_o1 a=%0d got=%h exp=a5", a, o1); end
        end
        $display("read_zero: swept 64 addresses");
    endtask

    task automatic test_write_read();
        A = 6'd7; D = 8'h5A; WE = 1'b1;
        #1;
        checks++; if (o1 !== 8'hA5) begin failures++; $display("FAIL pre_edge_o1 got=%h exp=a5", o1); end
        step(); WE = 1'b0; #1;
        checks++; if (o1 !== 8'h5A) begin failures++; $display("FAIL post_edge_o1 got=%h exp=5a", o1); end
        A = 6'd5; D = 8'h3C; WE = 1'b1;
        step(); WE = 1'b0; #1;
        checks++; if (o1 !== 8'h3C) begin failures++; $display("FAIL wr_a5_o1 got=%h exp=3c", o1); end
        A = 6'd6; #1;
        checks++; if (o1 !== 8'hA5) begin failures++; $display("FAIL rd_a6_o1 got=%h exp=a5", o1); end
        A = 6'd12; D = 8'h01; WE = 1'b1;
        step(); WE = 1'b0; #1;
        checks++; if (o0 !== 1'b1) begin failures++; $display("FAIL wr_a12_o0 got=%b exp=1", o0); end
        A = 6'd13; #1;
        checks++; if (o0 !== 1'b0) begin failures++; $display("FAIL rd_a13_o0 got=%b exp=0", o0); end
        $display("write_read: async read port writes done");
    endtask

    task automatic test_out_reg();
        A = 6'd9; D = 8'h11; WE = 1'b1;
        step();
        checks++; if (o2 !== 8'h00) begin failures++; $display("FAIL rf_first_o2 got=%h exp=00", o2); end
        checks++; if (o3 !== 8'h11) begin failures++; $display("FAIL wf_first_o3 got=%h exp=11", o3); end
        D = 8'h22;
        step();
        checks++; if (o2 !== 8'h11) begin failures++; $display("FAIL rf_old_o2 got=%h exp=11", o2); end
        checks++; if (o3 !== 8'h22) begin failures++; $display("FAIL wf_new_o3 got=%h exp=22", o3); end
        WE = 1'b0;
        step();
        checks++; if (o2 !== 8'h22) begin failures++; $display("FAIL rf_next_o2 got=%h exp=22", o2); end
        checks++; if (o3 !== 8'h22) begin failures++; $display("FAIL wf_next_o3 got=%h exp=22", o3); end
        A = 6'd5;
        step();
        checks++; if (o2 !== 8'h3C) begin failures++; $display("FAIL rd_a5_o2 got=%h exp=3c", o2); end
        checks++; if (o3 !== 8'h3C) begin failures++; $display("FAIL rd_a5_o3 got=%h exp=3c", o3); end
        $display("out_reg: read-first and write-first sequences done");
    endtask

    task automatic test_clr_priority();
        int n;
        A = 6'd3; D = 8'h01; WE = 1'b1; CLR = 1'b1;
        step();
        WE = 1'b0; CLR = 1'b0;
        checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL clr_enter_busy got=%b exp=1", busy0); end
        checks++; if (o3 !== 8'h01) begin failures++; $display("FAIL clr_enter_o3 got=%h exp=01", o3); end
        n = 0;
        while (busy0 === 1'b1 && n < 200) begin
            WE  = (n == 10);
            CLR = (n == 20);
            A   = (n == 10) ? 6'd4 : 6'd3;
            D   = 8'h77;
            step();
            n++;
        end
        WE = 1'b0; CLR = 1'b0;
        checks++; if (n != 64) begin failures++; $display("FAIL clr_len got=%0d exp=64", n); end
        checks++; if (o3 !== 8'h01) begin failures++; $display("FAIL clr_hold_o3 got=%h exp=01", o3); end
        A = 6'd3; #1;
        checks++; if (o0 !== 1'b0) begin failures++; $display("FAIL clr_a3_o0 got=%b exp=0", o0); end
        checks++; if (o1 !== 8'hA5) begin failures++; $display("FAIL clr_a3_o1 got=%h exp=a5", o1); end
        A = 6'd4; #1;
        checks++; if (o1 !== 8'hA5) begin failures++; $display("FAIL clr_a4_o1 got=%h exp=a5", o1); end
        $display("clr_priority: clear length %0d", n);
    endtask

    task automatic test_rst_mid_clear();
        int n;
        A = 6'd9; D = 8'h33; WE = 1'b1;
        step();
        WE = 1'b0;
        step();
        checks++; if (o2 !== 8'h33) begin failures++; $display("FAIL mid_pre_o2 got=%h exp=33", o2); end
        CLR = 1'b1;
        step();
        CLR = 1'b0;
        repeat (29) step();
        checks++; if (o2 !== 8'h33) begin failures++; $display("FAIL mid_hold_o2 got=%h exp=33", o2); end
        #2 RST = 1'b1;
        #1;
        checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL mid_rst_busy got=%b exp=1", busy0); end
        checks++; if (o2 !== 8'h00) begin failures++; $display("FAIL mid_rst_o2 got=%h exp=00", o2); end
        checks++; if (o3 !== 8'h00) begin failures++; $display("FAIL mid_rst_o3 got=%h exp=00", o3); end
        step(); step();
        RST = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (busy0 === 1'b1 && n < 200);
        checks++; if (n != 64) begin failures++; $display("FAIL mid_restart_len got=%0d exp=64", n); end
        #1;
        checks++; if (o1 !== 8'hA5) begin failures++; $display("FAIL mid_a9_o1 got=%h exp=a5", o1); end
        checks++; if (o0 !== 1'b0) begin failures++; $display("FAIL mid_a9_o0 got=%b exp=0", o0); end
        $display("rst_mid_clear: restart length %0d", n);
    endtask

    task automatic test_rising_edge();
        checks++; if (busy4 !== 1'b0) begin failures++; $display("FAIL rise_busy4 got=%b exp=0", busy4); end
        A4 = 6'd20; D4 = 8'hC3;
        step_rise();
        WE4 = 1'b1;
        step();
        WE4 = 1'b0;
        #1;
        checks++; if (o4 !== 8'h00) begin failures++; $display("FAIL rise_fall_only_o4 got=%h exp=00", o4); end
        WE4 = 1'b1;
        step_rise();
        WE4 = 1'b0;
        checks++; if (o4 !== 8'hC3) begin failures++; $display("FAIL rise_write_o4 got=%h exp=c3", o4); end
        A4 = 6'd21; #1;
        checks++; if (o4 !== 8'h00) begin failures++; $display("FAIL rise_a21_o4 got=%h exp=00", o4); end
        $display("rising_edge: rising-edge write checked");
    endtask

    initial begin
        test_reset();
        test_read_zero();
        test_write_read();
        test_out_reg();
        test_clr_priority();
        test_rst_mid_clear();
        test_rising_edge();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
